// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_byte_fifo.sv
// Power-of-two byte FIFO with registered pointers and occupancy count.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign rdata = mem[rd_ptr];

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART deframer feeding a byte FIFO on a valid/ready stream.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err pulse.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk50,
  input  logic                          reset,
  input  logic                          rx,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          frame_err,
  output logic                          overflow,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam logic [15:0] HALF = 16'(BAUD_DIV / 2 - 1);
  localparam logic [15:0] FULL = 16'(BAUD_DIV - 1);

  logic      rx_meta;
  logic      rx_s;

  rx_state_t state;
  rx_state_t state_n;
  logic [15:0] bcnt;
  logic [15:0] bcnt_n;
  logic [2:0]  idx;
  logic [2:0]  idx_n;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_n;

  logic tick;
  logic push;
  logic ferr;
  logic par_ok;
  logic full;
  logic empty;
  logic pop;
  logic ovf;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  logic par_n;
  logic perr;
`endif

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bcnt      <= '0;
      idx       <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      bcnt      <= bcnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      frame_err <= ferr;
      overflow  <= ovf;
`ifdef UART_RX_PARITY_EN
      par_bit    <= par_n;
      parity_err <= perr;
`endif
    end
  end

  assign tick = (bcnt == '0);

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    idx_n   = idx;
    shreg_n = shreg;
    push    = 1'b0;
    ferr    = 1'b0;
    par_ok  = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_n   = par_bit;
    perr    = 1'b0;
`endif
    // bcnt idles at zero, so a blanket decrement is safe in every state.
    if (!tick) bcnt_n = bcnt - 16'd1;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          bcnt_n  = HALF;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            bcnt_n  = FULL;
            idx_n   = '0;
            state_n = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
          bcnt_n  = FULL;
          if (idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
`ifdef UART_RX_PARITY_EN
          par_n = rx_s;
`endif
          bcnt_n  = FULL;
          state_n = STOP;
        end
      end
      STOP: begin
        if (tick) begin
`ifdef UART_RX_PARITY_EN
          par_ok = (even_parity(shreg) == par_bit);
          perr   = ~par_ok;
`endif
          push    = rx_s & par_ok;
          ferr    = ~rx_s;
          state_n = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign pop     = m_valid & m_ready;
  assign ovf     = push & full & ~pop;
  assign m_valid = ~empty;

  byte_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk50),
    .rst   (reset),
    .push  (push),
    .pop   (m_ready),
    .wdata (shreg),
    .rdata (m_data),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receives the SoC console stream on serial_tx of the de0nano top level (8N1, LSB first) and deframes it into bytes.
- Buffers the bytes in a small FIFO and presents them on a valid/ready stream. Downstream consumers are a bench log/scoreboard or an on-board loopback.
- Sits directly downstream of the SoC UART TX pin, in the clk50 domain.

Parameters:
- BAUD_DIV, 434, clk50 cycles per bit (50 MHz / 115200, truncated); legal range 4..65535.
- FIFO_DEPTH, 16, byte entries; power of two, 2..256.

Ports:
- clk50  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial line; idle high.
- m_data  out  8  head-of-FIFO byte.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts m_data when m_valid & m_ready.
- frame_err  out  1  one-cycle pulse per byte whose stop bit sampled low.
- overflow  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset values: m_valid=0, m_data=0, frame_err=0, overflow=0, fifo_count=0; synchronizer flops=1; FSM=IDLE; counters=0.
- Reset is asynchronous assert. Asserting reset mid-frame discards the partial byte and all FIFO contents.
- rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s. Latency from pin to rx_s is 2 cycles.
- Bit counter bcnt counts clk50 cycles. Bit index idx is 0..7.
- IDLE: on rx_s==0, load bcnt=BAUD_DIV/2-1 and go to START.
- START: bcnt decrements to 0. At 0, rx_s==1 is a glitch and returns to IDLE (no error). rx_s==0 reloads bcnt=BAUD_DIV-1, sets idx=0 and goes to DATA.
- DATA: at bcnt==0, shift rx_s into shreg[7] (right shift, LSB first). Then either idx++ with a reload, or after idx==7 reload and go to STOP (or PARITY if enabled).
- STOP: at bcnt==0:
  - rx_s==1: push shreg into the FIFO, go to IDLE.
  - rx_s==0: pulse frame_err, no push, go to BREAK.
- BREAK: wait for rx_s==1, then go to IDLE. A held-low line produces exactly one frame_err.
- Sampling point is mid-bit: the push happens (BAUD_DIV/2 + 9*BAUD_DIV) cycles after the synchronized falling edge, ±1.
- FIFO: registered pointers with wrap at FIFO_DEPTH. m_data is combinational read of mem[rd_ptr]. m_valid = (count != 0).
- Pop when m_valid & m_ready.
- Push when STOP completes good. It is accepted if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs the same cycle.
- Otherwise the byte is dropped and overflow pulses for one cycle; FIFO contents are unchanged.
- Simultaneous push and pop leaves count unchanged, and both pointers advance.
- m_ready asserted while empty has no effect; count never underflows.
- The receiver never stalls on back-pressure. Bytes are lost only through overflow.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that samples one even-parity bit (frame 8E1).
  - Adds output parity_err (1 bit, one-cycle pulse, reset 0).
  - On a mismatch the byte is not pushed and parity_err pulses at the STOP sample point. A frame with both a parity and a stop-bit error pulses both, in the same cycle.
- Undefined: 8N1 only; no parity_err port.

Decomposition:
- Package uart_rx_pkg:
  - typedef enum of states {IDLE, START, DATA, PARITY, STOP, BREAK}.
  - Function even_parity(byte).
  - Localparam DATA_BITS=8.
- One sub-module, byte_fifo (params WIDTH, DEPTH; push/pop/full/empty/count), instantiated once. The deframer FSM stays in uart_rx_fifo.

Test Plan:
Bench uses BAUD_DIV=8, FIFO_DEPTH=4 unless stated.
1. Send 0x55, then 0xA3, with m_ready=1. Expected: m_valid rises twice; m_data = 0x55 then 0xA3; no error pulses; fifo_count returns to 0.
2. Drive rx low for 3 cycles, then high. Expected: glitch rejected; no push, no frame_err; FSM back in IDLE.
3. Send 0x3C with the stop bit forced to 0 and the line held low for 40 cycles. Expected: exactly one frame_err pulse; fifo_count=0. A following 0x81 is received correctly.
4. Hold m_ready=0 and send 0x01..0x05. Expected: fifo_count=4 and one overflow pulse on 0x05. Releasing m_ready drains 0x01,0x02,0x03,0x04 in order.
5. With FIFO full, assert m_ready on the cycle 0x06 completes. Expected: 0x06 accepted, no overflow, count stays 4.
6. Assert reset mid-byte (after bit 3) with 2 bytes queued. Expected: m_valid=0 and fifo_count=0 immediately. The next full frame 0xF0 is received.
7. With UART_RX_PARITY_EN: 0x07 with parity=1 is pushed; 0x07 with parity=0 gives a parity_err pulse and no push.
